rom_download_sequencer: RTL and testbench

ROM_DOWNLOAD_SEQUENCER -- requirements
Module: rom_download_sequencer

---
 rtl/rom_download_sequencer.sv | 170 +++++++++++++++++
 tb/tb_rom_download_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_download_sequencer.sv
// Splits 16-bit loader words into two byte writes with a programmable idle gap,
// and tracks download completion, byte count, checksum and error flags.
module rom_download_sequencer #(
    parameter int ROM_SIZE  = 'h80000,
    parameter int DL_WR_GAP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic [24:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        dl_wr,
    output logic        rom_loaded,
    output logic [24:0] byte_count,
    output logic [15:0] checksum,
    output logic        overflow,
    output logic        drop_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOW   = 3'd1;
    localparam logic [2:0] S_GAP_L = 3'd2;
    localparam logic [2:0] S_HIGH  = 3'd3;
    localparam logic [2:0] S_GAP_H = 3'd4;

    localparam logic [25:0] ROM_LIMIT = 26'(ROM_SIZE);
    localparam logic [3:0]  GAP       = 4'(DL_WR_GAP);

    logic [2:0]  state, state_nx;
    logic [3:0]  gap_cnt, gap_nx;
    logic [24:0] cap_addr;
    logic [15:0] cap_data;
    logic        dl_prev;
    logic        load_pending;

    logic        capture;
    logic        emit;
    logic        in_range;
    logic        wr_ok;
    logic [24:0] byte_addr;
    logic [7:0]  byte_data;
    logic        rise, fall, finish;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        gap_nx    = gap_cnt;
        capture   = 1'b0;
        emit      = 1'b0;
        byte_addr = cap_addr;
        byte_data = cap_data[7:0];
        case (state)
            S_IDLE: begin
                if (ioctl_wr && ioctl_download) begin
                    capture   = 1'b1;
                    emit      = 1'b1;
                    state_nx  = S_LOW;
                    byte_addr = ioctl_addr & ~25'h1;
                    byte_data = ioctl_dout[7:0];
                end
            end
            S_LOW: begin
                if (GAP == 4'd0) begin
                    state_nx = S_HIGH;
                    emit     = 1'b1;
                end else begin
                    state_nx = S_GAP_L;
                    gap_nx   = GAP - 4'd1;
                end
            end
            S_GAP_L: begin
                if (gap_cnt == 4'd0) begin
                    state_nx = S_HIGH;
                    emit     = 1'b1;
                end else begin
                    gap_nx = gap_cnt - 4'd1;
                end
            end
            S_HIGH: begin
                if (GAP == 4'd0) begin
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_GAP_H;
                    gap_nx   = GAP - 4'd1;
                end
            end
            S_GAP_H: begin
                if (gap_cnt == 4'd0) state_nx = S_IDLE;
                else                 gap_nx   = gap_cnt - 4'd1;
            end
            default: state_nx = S_IDLE;
        endcase
        // Outputs are registered, so the byte is chosen from the state being entered.
        if (state_nx == S_HIGH) begin
            byte_addr = cap_addr | 25'h1;
            byte_data = cap_data[15:8];
        end
    end

    assign in_range = ({1'b0, byte_addr} < ROM_LIMIT);
    assign wr_ok    = emit && in_range;
    assign rise     = ioctl_download && !dl_prev;
    assign fall     = !ioctl_download && dl_prev;
    assign finish   = (load_pending || fall) && (state == S_IDLE);

    // NOTE: the word holding registers carry no reset; they are only read after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            cap_addr <= ioctl_addr & ~25'h1;
            cap_data <= ioctl_dout;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            gap_cnt      <= 4'd0;
            dl_prev      <= 1'b0;
            load_pending <= 1'b0;
            ioctl_wait   <= 1'b0;
            dl_wr        <= 1'b0;
            dl_addr      <= 25'd0;
            dl_data      <= 8'd0;
            rom_loaded   <= 1'b0;
            byte_count   <= 25'd0;
            checksum     <= 16'd0;
            overflow     <= 1'b0;
            drop_err     <= 1'b0;
        end else begin
            state      <= state_nx;
            gap_cnt    <= gap_nx;
            dl_prev    <= ioctl_download;
            ioctl_wait <= (state_nx != S_IDLE);
            dl_wr      <= wr_ok;
            if (emit) begin
                dl_addr <= byte_addr;
                dl_data <= byte_data;
            end

            // A new download restarts statistics, but a byte emitted now still counts.
            if (rise) begin
                byte_count <= 25'(wr_ok);
                checksum   <= wr_ok ? {8'd0, byte_data} : 16'd0;
                overflow   <= emit && !in_range;
                drop_err   <= ioctl_wr && (state != S_IDLE);
            end else begin
                byte_count <= byte_count + 25'(wr_ok);
                checksum   <= checksum + (wr_ok ? {8'd0, byte_data} : 16'd0);
                overflow   <= overflow || (emit && !in_range);
                drop_err   <= drop_err || (ioctl_wr && (state != S_IDLE));
            end

            if (rise) begin
                rom_loaded   <= 1'b0;
                load_pending <= 1'b0;
            end else if (finish) begin
                rom_loaded   <= 1'b1;
                load_pending <= 1'b0;
            end else if (fall) begin
                load_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_download_sequencer.sv
// Scoreboard bench: unit 0 runs with a one-cycle write gap, unit 1 with none;
// expected byte writes are queued at issue time and popped by a per-unit monitor.
module tb_rom_download_sequencer;

    localparam int ROM = 'h80000;

    typedef struct {
        int          c;
        logic [24:0] a;
        logic [7:0]  d;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst   [2];
    logic        dl    [2];
    logic        wr    [2];
    logic [24:0] addr  [2];
    logic [15:0] dout  [2];
    logic        wt    [2];
    logic [24:0] daddr [2];
    logic [7:0]  ddata [2];
    logic        dwr   [2];
    logic        ldd   [2];
    logic [24:0] bcnt  [2];
    logic [15:0] csum  [2];
    logic        ovf   [2];
    logic        drp   [2];

    rom_download_sequencer #(.ROM_SIZE(ROM), .DL_WR_GAP(1)) u_gap1 (
        .clk(clk), .reset(rst[0]), .ioctl_download(dl[0]), .ioctl_wr(wr[0]),
        .ioctl_addr(addr[0]), .ioctl_dout(dout[0]), .ioctl_wait(wt[0]),
        .dl_addr(daddr[0]), .dl_data(ddata[0]), .dl_wr(dwr[0]), .rom_loaded(ldd[0]),
        .byte_count(bcnt[0]), .checksum(csum[0]), .overflow(ovf[0]), .drop_err(drp[0])
    );

    rom_download_sequencer #(.ROM_SIZE(ROM), .DL_WR_GAP(0)) u_gap0 (
        .clk(clk), .reset(rst[1]), .ioctl_download(dl[1]), .ioctl_wr(wr[1]),
        .ioctl_addr(addr[1]), .ioctl_dout(dout[1]), .ioctl_wait(wt[1]),
        .dl_addr(daddr[1]), .dl_data(ddata[1]), .dl_wr(dwr[1]), .rom_loaded(ldd[1]),
        .byte_count(bcnt[1]), .checksum(csum[1]), .overflow(ovf[1]), .drop_err(drp[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    ev_t         q0[$];
    ev_t         q1[$];
    int          wstart [2];
    int          wend   [2];
    int          m_cnt  [2];
    logic [15:0] m_sum  [2];
    bit          m_ovf  [2];
    bit          m_drop [2];
    bit          mon_en = 1'b0;

    task automatic check(input string name, input int u, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s unit%0d @%0d: got %h expected %h", name, u, cyc, act, exp);
        end
    endtask

    function automatic int gap_of(input int u);
        return (u == 0) ? 1 : 0;
    endfunction

    function automatic int qsize(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ev_t qfront(input int u);
        return (u == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void qpop(input int u);
        if (u == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endfunction

    function automatic void qpush(input int u, input ev_t e);
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic void clear_model(input int u);
        m_cnt[u]  = 0;
        m_sum[u]  = 16'd0;
        m_ovf[u]  = 1'b0;
        m_drop[u] = 1'b0;
    endfunction

    task automatic mon(input int u);
        ev_t e;
        if (!mon_en) return;
        check("ioctl_wait", u, 32'(wt[u]), 32'(cyc >= wstart[u] && cyc <= wend[u]));
        while (qsize(u) > 0 && qfront(u).c < cyc) begin
            e = qfront(u);
            check("dl_wr_missing", u, 32'(e.a), 32'hFFFF_FFFF);
            qpop(u);
        end
        if (dwr[u] === 1'b1) begin
            if (qsize(u) == 0) begin
                check("dl_wr_spurious", u, 32'(daddr[u]), 32'hFFFF_FFFF);
            end else begin
                e = qfront(u);
                check("dl_wr_cycle", u, cyc, e.c);
                check("dl_addr", u, 32'(daddr[u]), 32'(e.a));
                check("dl_data", u, 32'(ddata[u]), 32'(e.d));
                qpop(u);
            end
        end else if (dwr[u] !== 1'b0) begin
            check("dl_wr_known", u, 32'(dwr[u]), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one word once the unit is ready; the expected byte writes follow from the
    // address and data alone: low byte one cycle later, high byte after the gap.
    task automatic send(input int u, input logic [24:0] a, input logic [15:0] d,
                        input bit inject = 1'b0, input bit abort = 1'b0,
                        input bit fall = 1'b0);
        int          t = 0;
        int          n;
        int          g = gap_of(u);
        logic [24:0] lo;
        logic [24:0] hi;
        while (wt[u] !== 1'b0 && t < 100) begin
            step();
            t++;
        end
        check("ready_before_word", u, 32'(t < 100), 32'd1);
        n = cyc;
        wr[u] = 1'b1;
        addr[u] = a;
        dout[u] = d;
        lo = {a[24:1], 1'b0};
        hi = {a[24:1], 1'b1};
        if (int'(lo) < ROM) begin
            qpush(u, '{c: n + 1, a: lo, d: d[7:0]});
            m_cnt[u]++;
            m_sum[u] += {8'd0, d[7:0]};
        end else begin
            m_ovf[u] = 1'b1;
        end
        if (!abort) begin
            if (int'(hi) < ROM) begin
                qpush(u, '{c: n + 2 + g, a: hi, d: d[15:8]});
                m_cnt[u]++;
                m_sum[u] += {8'd0, d[15:8]};
            end else begin
                m_ovf[u] = 1'b1;
            end
        end
        wstart[u] = n + 1;
        wend[u]   = abort ? n + 1 : n + 2 + 2 * g;
        step();
        wr[u] = 1'b0;
        if (fall) dl[u] = 1'b0;
        if (inject) begin
            wr[u] = 1'b1;
            addr[u] = 25'($urandom_range(0, 'h7FFFF));
            dout[u] = 16'($urandom);
            m_drop[u] = 1'b1;
            step();
            wr[u] = 1'b0;
        end
        if (abort) begin
            rst[u] = 1'b1;
            clear_model(u);
            step();
            rst[u] = 1'b0;
        end
    endtask

    task automatic dl_rise(input int u);
        dl[u] = 1'b1;
        clear_model(u);
        step();
    endtask

    task automatic check_stats(input int u);
        int t = 0;
        while (wt[u] !== 1'b0 && t < 100) begin
            step();
            t++;
        end
        check("idle_reached", u, 32'(t < 100), 32'd1);
        step();
        step();
        check("byte_count", u, 32'(bcnt[u]), 32'(m_cnt[u]));
        check("checksum", u, 32'(csum[u]), 32'(m_sum[u]));
        check("overflow", u, 32'(ovf[u]), 32'(m_ovf[u]));
        check("drop_err", u, 32'(drp[u]), 32'(m_drop[u]));
    endtask

    task automatic check_reset_outputs(input int u);
        check("rst_ioctl_wait", u, 32'(wt[u]), 32'd0);
        check("rst_dl_wr", u, 32'(dwr[u]), 32'd0);
        check("rst_dl_addr", u, 32'(daddr[u]), 32'd0);
        check("rst_dl_data", u, 32'(ddata[u]), 32'd0);
        check("rst_rom_loaded", u, 32'(ldd[u]), 32'd0);
        check("rst_byte_count", u, 32'(bcnt[u]), 32'd0);
        check("rst_checksum", u, 32'(csum[u]), 32'd0);
        check("rst_overflow", u, 32'(ovf[u]), 32'd0);
        check("rst_drop_err", u, 32'(drp[u]), 32'd0);
    endtask

    initial begin
        int t;
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1;
            dl[u] = 1'b0;
            wr[u] = 1'b0;
            addr[u] = 25'd0;
            dout[u] = 16'd0;
            wstart[u] = 1;
            wend[u] = 0;
            clear_model(u);
        end
        repeat (3) step();
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        step();
        mon_en = 1'b1;

        // Single word with a one-cycle gap.
        dl_rise(0);
        send(0, 25'h000010, 16'hBEEF);
        check_stats(0);
        check("beef_count", 0, 32'(bcnt[0]), 32'd2);
        check("beef_checksum", 0, 32'(csum[0]), 32'h01AD);

        // Strobe while busy is discarded and flagged.
        send(0, 25'h000020, 16'h1234, 1'b1);
        check_stats(0);

        // ROM boundary: last in-range word, then a fully out-of-range word.
        dl[0] = 1'b0;
        step();
        dl_rise(0);
        send(0, 25'h07FFFE, 16'hA1B2);
        send(0, 25'h080000, 16'hC3D4);
        check_stats(0);
        check("boundary_count", 0, 32'(bcnt[0]), 32'd2);
        check("boundary_overflow", 0, 32'(ovf[0]), 32'd1);

        // Random words around the boundary with random idle spacing.
        for (int i = 0; i < 40; i++) begin
            send(0, 25'('h7FF00 + $urandom_range(0, 'h1FF)), 16'($urandom));
            repeat ($urandom_range(0, 3)) step();
        end
        check_stats(0);

        // Download ends right after a strobe; completion waits for the word.
        send(0, 25'($urandom_range(0, 'h3FFFF)), 16'($urandom), 1'b0, 1'b0, 1'b1);
        t = 0;
        while (wt[0] === 1'b1 && t < 20) begin
            check("loaded_while_busy", 0, 32'(ldd[0]), 32'd0);
            step();
            t++;
        end
        step();
        step();
        check("loaded_after_idle", 0, 32'(ldd[0]), 32'd1);
        repeat (5) step();
        check("loaded_sticky", 0, 32'(ldd[0]), 32'd1);
        check_stats(0);

        // New download clears completion; reset mid-word aborts the high byte.
        dl_rise(0);
        check("loaded_cleared_on_rise", 0, 32'(ldd[0]), 32'd0);
        send(0, 25'h000030, 16'hA55A, 1'b0, 1'b1);
        check_reset_outputs(0);
        repeat (4) step();

        // Back-to-back burst at the maximum rate with no gap.
        dl_rise(1);
        for (int i = 0; i < 1024; i++) begin
            send(1, 25'(i * 2), 16'($urandom));
        end
        dl[1] = 1'b0;
        step();
        check_stats(1);
        check("burst_count", 1, 32'(bcnt[1]), 32'd2048);
        check("burst_loaded", 1, 32'(ldd[1]), 32'd1);
        check("burst_no_drop", 1, 32'(drp[1]), 32'd0);

        repeat (3) step();
        check("queue0_drained", 0, 32'(q0.size()), 32'd0);
        check("queue1_drained", 1, 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
